// File: rtl/alu_flag_capture_pkg.sv
// Shared definitions for the ALU flag capture stage.
// Flag bit positions match the ALU status vector packing.
package alu_flag_capture_pkg;

    localparam int FLAG_W    = 5;
    localparam int FLG_SIGN  = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_CARRY = 3;
    localparam int FLG_PAR   = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/alu_flag_capture_skid.sv
// Two-entry skid FIFO with a registered ready.
// Entry e0 is always the head; e1 only holds data when full.
module skid_fifo2
    import alu_flag_capture_pkg::*;
#(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_t         cnt;
    occ_t         cnt_nxt;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         rdy;
    logic         push;
    logic         pop;

    assign push      = in_valid & rdy;
    assign pop       = (cnt != OCC_EMPTY) & out_ready;
    assign in_ready  = rdy;
    assign out_valid = (cnt != OCC_EMPTY);
    assign out_data  = e0;

    always_comb begin
        cnt_nxt = cnt;
        unique case (cnt)
            OCC_EMPTY: if (push) cnt_nxt = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)
                    cnt_nxt = OCC_FULL;
                else if (!push && pop)
                    cnt_nxt = OCC_EMPTY;
            end
            OCC_FULL: if (pop) cnt_nxt = OCC_ONE;
            default: cnt_nxt = OCC_EMPTY;
        endcase
    end

    // ready is held low through reset and rises on the first edge after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= OCC_EMPTY;
            rdy <= 1'b0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            cnt <= cnt_nxt;
            rdy <= (cnt_nxt != OCC_FULL);
            unique case (cnt)
                OCC_EMPTY: if (push) e0 <= in_data;
                OCC_ONE: begin
                    if (push && pop)
                        e0 <= in_data;
                    else if (push)
                        e1 <= in_data;
                end
                OCC_FULL: if (pop) e0 <= e1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_flag_capture.sv
// Registered capture of ALU result and flags behind a skid FIFO,
// with sticky flags and a saturating overflow-event counter.
module alu_flag_capture
    import alu_flag_capture_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_z,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_z,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam int W = DW + FLAG_W;

    logic [W-1:0] head;
    logic         push;
    logic         ovf_push;

    skid_fifo2 #(
        .W(W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_flags, in_z}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

    assign out_z     = head[DW-1:0];
    assign out_flags = head[W-1:DW];
    assign push      = in_valid & in_ready;
    assign ovf_push  = push & in_flags[FLG_OVF];

    // a clear coinciding with a push keeps that push's contribution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            ovf_count    <= '0;
        end else if (clr_sticky) begin
            sticky_flags <= push ? in_flags : '0;
            ovf_count    <= ovf_push ? CNT_W'(1) : '0;
        end else begin
            if (push)
                sticky_flags <= sticky_flags | in_flags;
            if (ovf_push && (ovf_count != '1))
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule
